// File: rtl/lsb_mem_port_pkg.sv
// Shared definitions for the load/store buffer memory port: op codes,
// FSM encodings, address width and the IO window base.
package lsb_mem_port_pkg;

   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;

   localparam int          ADDR_WIDTH      = 32;
   localparam logic [31:0] IO_BASE_DEFAULT = 32'h0003_0000;

   // Memory op codes carried on op_type_load / op_type_store
   localparam logic [5:0] LB  = 6'd1;
   localparam logic [5:0] LH  = 6'd2;
   localparam logic [5:0] LW  = 6'd3;
   localparam logic [5:0] LBU = 6'd4;
   localparam logic [5:0] LHU = 6'd5;
   localparam logic [5:0] SB  = 6'd6;
   localparam logic [5:0] SH  = 6'd7;
   localparam logic [5:0] SW  = 6'd8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      STORE = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Number of bytes moved by an op; unknown codes move a full word
   function automatic logic [2:0] op_bytes(input logic [5:0] op);
      case (op)
         LB, LBU, SB: op_bytes = 3'd1;
         LH, LHU, SH: op_bytes = 3'd2;
         default:     op_bytes = 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/lsb_mem_port_load_extend.sv
// Sign/zero extension of an assembled little-endian word according to the
// load op code. Purely combinational so it can be shared with other paths.
module load_extend
   import lsb_mem_port_pkg::*;
(
   input  logic [31:0] word,
   input  logic [5:0]  op,
   output logic [31:0] result
);

   // Select the extension for the op; full-word and unknown ops pass through
   always_comb begin
      result = word;
      case (op)
         LB:      result = {{24{word[7]}}, word[7:0]};
         LH:      result = {{16{word[15]}}, word[15:0]};
         LBU:     result = {24'b0, word[7:0]};
         LHU:     result = {16'b0, word[15:0]};
         default: result = word;
      endcase
   end

endmodule

// File: rtl/lsb_mem_port.sv
// Memory-side responder for the load/store buffer. Serialises one load or
// store at a time onto the byte-wide RAM port and answers with a one-cycle
// finish pulse. The RAM has one cycle of read latency, so loads capture
// byte k two counter steps after its address was issued.
module lsb_mem_port
   import lsb_mem_port_pkg::*;
#(
   parameter logic [31:0] IO_BASE = IO_BASE_DEFAULT
)(
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  rdy_in,
   input  logic                  roll_back,
   input  logic                  lsb_load,
   input  logic [ADDR_WIDTH-1:0] load_address,
   input  logic [5:0]            op_type_load,
   output logic                  finish_load,
   output logic [31:0]           data_load,
   input  logic                  lsb_store,
   input  logic [ADDR_WIDTH-1:0] store_address,
   input  logic [31:0]           data_store,
   input  logic [5:0]            op_type_store,
   output logic                  finish_store,
   input  logic                  io_buffer_full,
   input  logic [7:0]            mem_din,
   output logic [7:0]            mem_dout,
   output logic [31:0]           mem_a,
   output logic                  mem_wr
);

   state_t      state_reg, state_next;
   logic [2:0]  cnt_reg, cnt_next;
   logic [2:0]  nbytes_reg, nbytes_next;
   logic [31:0] addr_reg, addr_next;
   logic [31:0] data_reg, data_next;
   logic [31:0] word_reg, word_next;
   logic [5:0]  op_reg, op_next;
   logic        is_load_reg, is_load_next;
   logic        finish_load_reg, finish_load_next;
   logic        finish_store_reg, finish_store_next;
   logic [31:0] data_load_reg, data_load_next;
   logic [7:0]  mem_dout_reg, mem_dout_next;
   logic [31:0] mem_a_reg, mem_a_next;
   logic        mem_wr_reg, mem_wr_next;

   logic        cap_en;
   logic [1:0]  cap_lane;
   logic [31:0] word_cap;
   logic [31:0] word_ext;
   logic        io_hit;

   assign io_hit = (store_address >= IO_BASE) && (store_address <= IO_BASE + 32'd7);

   load_extend u_load_extend (
      .word   (word_cap),
      .op     (op_reg),
      .result (word_ext)
   );

   // Merge the byte arriving from RAM into its lane of the assembled word
   always_comb begin
      cap_en   = FALSE;
      cap_lane = 2'd0;
      if (state_reg == LOAD && cnt_reg >= 3'd2) begin
         cap_en   = TRUE;
         cap_lane = 2'(cnt_reg - 3'd2);
      end else if (state_reg == DONE && is_load_reg) begin
         cap_en   = TRUE;
         cap_lane = 2'(nbytes_reg - 3'd1);
      end
      word_cap = word_reg;
      if (cap_en) begin
         word_cap[{cap_lane, 3'b000} +: 8] = mem_din;
      end
   end

   // Next-state and registered-output logic of the request FSM
   always_comb begin
      state_next        = state_reg;
      cnt_next          = cnt_reg;
      nbytes_next       = nbytes_reg;
      addr_next         = addr_reg;
      data_next         = data_reg;
      word_next         = word_cap;
      op_next           = op_reg;
      is_load_next      = is_load_reg;
      finish_load_next  = FALSE;
      finish_store_next = FALSE;
      data_load_next    = data_load_reg;
      mem_dout_next     = mem_dout_reg;
      mem_a_next        = mem_a_reg;
      mem_wr_next       = FALSE;
      case (state_reg)
         IDLE: begin
            // A request is still held high during its finish cycle; skip it
            if (!roll_back && !finish_load_reg && !finish_store_reg) begin
               if (lsb_store) begin
                  if (!(io_hit && io_buffer_full)) begin
                     addr_next    = store_address;
                     data_next    = data_store;
                     op_next      = op_type_store;
                     nbytes_next  = op_bytes(op_type_store);
                     cnt_next     = 3'd0;
                     is_load_next = FALSE;
                     state_next   = STORE;
                  end
               end else if (lsb_load) begin
                  addr_next    = load_address;
                  op_next      = op_type_load;
                  nbytes_next  = op_bytes(op_type_load);
                  cnt_next     = 3'd0;
                  word_next    = 32'd0;
                  is_load_next = TRUE;
                  state_next   = LOAD;
               end
            end
         end
         LOAD: begin
            if (roll_back) begin
               state_next = IDLE;
            end else if (cnt_reg < nbytes_reg) begin
               mem_a_next = addr_reg + {29'b0, cnt_reg};
               cnt_next   = cnt_reg + 3'd1;
            end else begin
               state_next = DONE;
            end
         end
         STORE: begin
            mem_a_next    = addr_reg + {29'b0, cnt_reg};
            mem_dout_next = data_reg[{cnt_reg[1:0], 3'b000} +: 8];
            mem_wr_next   = TRUE;
            cnt_next      = cnt_reg + 3'd1;
            if (cnt_reg == nbytes_reg - 3'd1) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
            if (is_load_reg) begin
               if (!roll_back) begin
                  finish_load_next = TRUE;
                  data_load_next   = word_ext;
               end
            end else begin
               finish_store_next = TRUE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State and output registers; everything freezes while rdy_in is low
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_reg        <= IDLE;
         cnt_reg          <= 3'd0;
         nbytes_reg       <= 3'd0;
         addr_reg         <= 32'd0;
         data_reg         <= 32'd0;
         word_reg         <= 32'd0;
         op_reg           <= 6'd0;
         is_load_reg      <= FALSE;
         finish_load_reg  <= FALSE;
         finish_store_reg <= FALSE;
         data_load_reg    <= 32'd0;
         mem_dout_reg     <= 8'd0;
         mem_a_reg        <= 32'd0;
         mem_wr_reg       <= FALSE;
      end else if (rdy_in) begin
         state_reg        <= state_next;
         cnt_reg          <= cnt_next;
         nbytes_reg       <= nbytes_next;
         addr_reg         <= addr_next;
         data_reg         <= data_next;
         word_reg         <= word_next;
         op_reg           <= op_next;
         is_load_reg      <= is_load_next;
         finish_load_reg  <= finish_load_next;
         finish_store_reg <= finish_store_next;
         data_load_reg    <= data_load_next;
         mem_dout_reg     <= mem_dout_next;
         mem_a_reg        <= mem_a_next;
         mem_wr_reg       <= mem_wr_next;
      end
   end

   assign finish_load  = finish_load_reg;
   assign finish_store = finish_store_reg;
   assign data_load    = data_load_reg;
   assign mem_dout     = mem_dout_reg;
   assign mem_a        = mem_a_reg;
   // The held write strobe must not repeat a write while the RAM is paused
   assign mem_wr       = mem_wr_reg & rdy_in;

endmodule

// File: tb/tb_lsb_mem_port.sv
// Directed bench for lsb_mem_port with a byte RAM model of one-cycle read
// latency that stalls on rdy_in like the real RAM.
module tb_lsb_mem_port;
   import lsb_mem_port_pkg::*;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b1;
   logic        rdy_in = 1'b1;
   logic        roll_back = 1'b0;
   logic        lsb_load = 1'b0;
   logic [31:0] load_address = 32'd0;
   logic [5:0]  op_type_load = 6'd0;
   logic        lsb_store = 1'b0;
   logic [31:0] store_address = 32'd0;
   logic [31:0] data_store = 32'd0;
   logic [5:0]  op_type_store = 6'd0;
   logic        io_buffer_full = 1'b0;
   logic [7:0]  mem_din;
   logic        finish_load, finish_store, mem_wr;
   logic [31:0] data_load, mem_a;
   logic [7:0]  mem_dout;

   logic [7:0]  ram [0:1023];
   int          total = 0;
   int          bad = 0;

   lsb_mem_port dut (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .rdy_in         (rdy_in),
      .roll_back      (roll_back),
      .lsb_load       (lsb_load),
      .load_address   (load_address),
      .op_type_load   (op_type_load),
      .finish_load    (finish_load),
      .data_load      (data_load),
      .lsb_store      (lsb_store),
      .store_address  (store_address),
      .data_store     (data_store),
      .op_type_store  (op_type_store),
      .finish_store   (finish_store),
      .io_buffer_full (io_buffer_full),
      .mem_din        (mem_din),
      .mem_dout       (mem_dout),
      .mem_a          (mem_a),
      .mem_wr         (mem_wr)
   );

   always #5 clk_in = ~clk_in;

   always @(posedge clk_in) begin
      if (rdy_in) mem_din <= ram[mem_a[9:0]];
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish (total=%0d bad=%0d)", total, bad);
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
      $display("check %s: got %h want %h", tag, obs, exp);
   endtask

   task automatic chkb(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %b want %b", tag, obs, exp);
      end
   endtask

   task automatic do_load(input logic [31:0] addr, input logic [5:0] op, input int n,
                          input logic [31:0] exp, input int stall_at);
      lsb_load     = 1'b1;
      load_address = addr;
      op_type_load = op;
      tick();
      for (int c = 1; c <= n + 1; c++) begin
         tick();
         if (c <= n) chk("ld_addr", mem_a, addr + 32'(c - 1));
         chkb("ld_wr", mem_wr, 1'b0);
         chkb("ld_early_finish", finish_load, 1'b0);
         if (c == stall_at) begin
            rdy_in = 1'b0;
            for (int s = 0; s < 3; s++) begin
               tick();
               chk("ld_stall_addr", mem_a, addr + 32'(c - 1));
               chkb("ld_stall_finish", finish_load, 1'b0);
            end
            rdy_in = 1'b1;
         end
      end
      tick();
      chkb("ld_finish", finish_load, 1'b1);
      chk("ld_data", data_load, exp);
      lsb_load = 1'b0;
      tick();
      chkb("ld_finish_drop", finish_load, 1'b0);
   endtask

   task automatic do_store(input logic [31:0] addr, input logic [5:0] op, input logic [31:0] data,
                           input int n, input logic rb, input int stall_at);
      lsb_store     = 1'b1;
      store_address = addr;
      op_type_store = op;
      data_store    = data;
      tick();
      for (int c = 1; c <= n; c++) begin
         tick();
         chk("st_addr", mem_a, addr + 32'(c - 1));
         chkb("st_wr", mem_wr, 1'b1);
         chk("st_byte", {24'b0, mem_dout}, {24'b0, data[8*(c-1) +: 8]});
         chkb("st_early_finish", finish_store, 1'b0);
         if (rb && c == 1) roll_back = 1'b1;
         if (c == stall_at) begin
            rdy_in = 1'b0;
            for (int s = 0; s < 3; s++) begin
               tick();
               chkb("st_stall_wr", mem_wr, 1'b0);
               chk("st_stall_addr", mem_a, addr + 32'(c - 1));
            end
            rdy_in = 1'b1;
         end
      end
      tick();
      chkb("st_finish", finish_store, 1'b1);
      chkb("st_wr_after", mem_wr, 1'b0);
      lsb_store = 1'b0;
      roll_back = 1'b0;
      tick();
      chkb("st_finish_drop", finish_store, 1'b0);
   endtask

   task automatic blocked_store(input logic [31:0] addr, input logic [31:0] data, input int cycles);
      lsb_store      = 1'b1;
      store_address  = addr;
      op_type_store  = SB;
      data_store     = data;
      io_buffer_full = 1'b1;
      for (int k = 0; k < cycles; k++) begin
         tick();
         chkb("io_blocked_wr", mem_wr, 1'b0);
         chkb("io_blocked_finish", finish_store, 1'b0);
      end
      io_buffer_full = 1'b0;
      do_store(addr, SB, data, 1, 1'b0, 0);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
      ram[10'h100] = 8'h11; ram[10'h101] = 8'h22; ram[10'h102] = 8'h33; ram[10'h103] = 8'h44;
      ram[10'h104] = 8'h55; ram[10'h105] = 8'h66; ram[10'h106] = 8'h77; ram[10'h107] = 8'h88;
      ram[10'h110] = 8'h80;
      ram[10'h120] = 8'h01; ram[10'h121] = 8'h80;
      ram[10'h3FF] = 8'h34; ram[10'h000] = 8'h12;

      // reset state
      #1 rst_in = 1'b0;
      #2;
      chkb("rst_finish_load", finish_load, 1'b0);
      chkb("rst_finish_store", finish_store, 1'b0);
      chk("rst_data_load", data_load, 32'd0);
      chk("rst_mem_dout", {24'b0, mem_dout}, 32'd0);
      chk("rst_mem_a", mem_a, 32'd0);
      chkb("rst_mem_wr", mem_wr, 1'b0);
      tick();
      tick();
      rst_in = 1'b1;
      tick();

      // word load and extension variants, misaligned and wrapping addresses
      do_load(32'h0000_0100, LW, 4, 32'h4433_2211, 0);
      do_load(32'h0000_0110, LB, 1, 32'hFFFF_FF80, 0);
      do_load(32'h0000_0110, LBU, 1, 32'h0000_0080, 0);
      do_load(32'h0000_0120, LH, 2, 32'hFFFF_8001, 0);
      do_load(32'h0000_0120, LHU, 2, 32'h0000_8001, 0);
      do_load(32'h0000_0101, LW, 4, 32'h5544_3322, 0);
      do_load(32'hFFFF_FFFF, LHU, 2, 32'h0000_1234, 0);

      // roll_back in IDLE blocks acceptance for that edge
      lsb_load     = 1'b1;
      load_address = 32'h0000_0110;
      op_type_load = LB;
      roll_back    = 1'b1;
      tick();
      roll_back = 1'b0;
      do_load(32'h0000_0110, LB, 1, 32'hFFFF_FF80, 0);

      // stores, including a paused byte
      do_store(32'h0000_0200, SH, 32'hDEAD_BEEF, 2, 1'b0, 0);
      do_store(32'h0000_0208, SB, 32'h0000_0077, 1, 1'b0, 1);

      // IO window back-pressure at both ends, and just past the window
      blocked_store(32'h0003_0000, 32'h0000_005A, 10);
      blocked_store(32'h0003_0007, 32'h0000_00C3, 3);
      io_buffer_full = 1'b1;
      do_store(32'h0003_0008, SB, 32'h0000_00A5, 1, 1'b0, 0);
      io_buffer_full = 1'b0;

      // flushed load gives no finish; next load completes normally
      lsb_load     = 1'b1;
      load_address = 32'h0000_0100;
      op_type_load = LW;
      tick();
      tick();
      tick();
      tick();
      roll_back = 1'b1;
      lsb_load  = 1'b0;
      tick();
      roll_back = 1'b0;
      chkb("rb_no_finish", finish_load, 1'b0);
      do_load(32'h0000_0104, LW, 4, 32'h8877_6655, 0);

      // committed store ignores roll_back
      do_store(32'h0000_0300, SW, 32'hCAFE_F00D, 4, 1'b1, 0);

      // pause mid-load
      do_load(32'h0000_0104, LW, 4, 32'h8877_6655, 2);

      // asynchronous reset mid-store
      lsb_store     = 1'b1;
      store_address = 32'h0000_0400;
      op_type_store = SW;
      data_store    = 32'h0102_0304;
      tick();
      tick();
      chkb("rst_sw_wr", mem_wr, 1'b1);
      tick();
      chk("rst_sw_addr", mem_a, 32'h0000_0401);
      rst_in = 1'b0;
      #1;
      chk("arst_mem_a", mem_a, 32'd0);
      chkb("arst_mem_wr", mem_wr, 1'b0);
      chk("arst_mem_dout", {24'b0, mem_dout}, 32'd0);
      chk("arst_data_load", data_load, 32'd0);
      chkb("arst_finish_load", finish_load, 1'b0);
      chkb("arst_finish_store", finish_store, 1'b0);
      lsb_store = 1'b0;
      tick();
      tick();
      rst_in = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         chkb("post_rst_finish", finish_store, 1'b0);
         chkb("post_rst_wr", mem_wr, 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
